// File: rtl/sram_lsu_bridge_if.sv
// sram_lsu_bridge_if: CPU load/store request/response channel plus the SRAM port, bundled.
//   req_*  : byte-addressed request (valid/ready), rsp_* : response (valid/ready)
//   mem_*  : SRAM enable, byte write enables, word address, write data, read data
//   slave  : bridge view, master : requester + SRAM view
interface sram_lsu_bridge_if #(parameter int ADDR_WIDTH = 16);
  logic req_valid, req_ready, req_we, req_signed;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic mem_ena;
  logic [3:0] mem_wea;
  logic [ADDR_WIDTH-1:0] mem_addra;
  logic [31:0] mem_dina, mem_douta;
  modport slave (
    input req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready, mem_douta,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ena, mem_wea, mem_addra, mem_dina
  );
  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready, mem_douta,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ena, mem_wea, mem_addra, mem_dina
  );
endinterface

// File: rtl/sram_lsu_bridge.sv
// sram_lsu_bridge: byte-addressed load/store front end for a word-wide, byte-writable sync SRAM.
//   clk, rst : clock (also SRAM clock), async active-high reset
//   bus      : slave side of sram_lsu_bridge_if (request, response, SRAM port)
module sram_lsu_bridge #(
  parameter int ADDR_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  sram_lsu_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t state;
  logic [1:0] off, size;
  logic sgn, acc, err, go, unused_hi;
  logic [3:0] mask;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ext;
  assign bus.req_ready = state == IDLE && !rst;
  assign acc = bus.req_valid && bus.req_ready;
  assign err = bus.req_size == 2'd3 || (bus.req_size == 2'd1 && bus.req_addr[0]) ||
               (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
  assign go = acc && !err;
  // upper address bits wrap modulo SRAM size
  assign unused_hi = ^bus.req_addr[31:ADDR_WIDTH+2];
  always_comb begin
    mask = bus.req_size == 2'd0 ? 4'b0001 << bus.req_addr[1:0] :
           bus.req_size == 2'd1 ? 4'b0011 << {bus.req_addr[1], 1'b0} : 4'b1111;
  end
  assign bus.mem_ena = go;
  assign bus.mem_wea = go && bus.req_we ? mask : 4'b0000;
  assign bus.mem_addra = bus.req_addr[ADDR_WIDTH+1:2];
  assign bus.mem_dina = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                        bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  assign bus.rsp_valid = state == RESP;
  // lane select from the latched offset; douta is valid in RD_WAIT
  assign b = bus.mem_douta[{off, 3'b000} +: 8];
  assign h = bus.mem_douta[{off[1], 4'b0000} +: 16];
  assign ext = size == 2'd0 ? {{24{sgn & b[7]}}, b} :
               size == 2'd1 ? {{16{sgn & h[15]}}, h} : bus.mem_douta;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      off <= '0;
      size <= '0;
      sgn <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          off <= bus.req_addr[1:0];
          size <= bus.req_size;
          sgn <= bus.req_signed;
          bus.rsp_err <= err;
          bus.rsp_rdata <= '0;
          state <= err || bus.req_we ? RESP : RD_WAIT;
        end
        RD_WAIT: begin
          bus.rsp_rdata <= ext;
          state <= RESP;
        end
        RESP: if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_lsu_bridge.sv
// tb_sram_lsu_bridge: directed scoreboard bench for sram_lsu_bridge with a behavioural SRAM.
module tb_sram_lsu_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [32:0] sb[$];
  logic [31:0] ram [0:65535];
  sram_lsu_bridge_if #(.ADDR_WIDTH(16)) bus();
  sram_lsu_bridge #(.ADDR_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_ena) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_wea[i]) ram[bus.mem_addra][8*i +: 8] <= bus.mem_dina[8*i +: 8];
      bus.mem_douta <= ram[bus.mem_addra];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] wd, input logic e_ena, input logic [3:0] e_wea,
                     input logic [15:0] e_addr, input logic [31:0] e_dina, input logic [31:0] e_rd,
                     input logic e_err);
    int n;
    logic [32:0] e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_size = sz;
    bus.req_signed = sg;
    bus.req_wdata = wd;
    bus.rsp_ready = 1'b1;
    #1;
    chk("req_ready", bus.req_ready, 1);
    chk("mem_ena", bus.mem_ena, e_ena);
    chk("mem_wea", bus.mem_wea, e_wea);
    if (e_ena) chk("mem_addra", bus.mem_addra, e_addr);
    if (e_wea != 4'b0000) chk("mem_dina", bus.mem_dina, e_dina);
    sb.push_back({e_err, e_rd});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("post_ena", bus.mem_ena, 0);
    n = 1;
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, (e_ena && !we) ? 2 : 1);
    chk("rsp_valid", bus.rsp_valid, 1);
    e = sb.pop_front();
    chk("rsp_rdata", bus.rsp_rdata, e[31:0]);
    chk("rsp_err", bus.rsp_err, e[32]);
    @(posedge clk);
    #1;
    chk("rsp_done", bus.rsp_valid, 0);
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    bus.mem_douta = '0;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 32'h10;
    bus.req_size = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    #2;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mem_ena", bus.mem_ena, 0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", bus.req_ready, 1);
    req(1, 32'h10, 2, 0, 32'hDEADBEEF, 1, 4'hF, 16'd4, 32'hDEADBEEF, 32'h0, 0);
    req(0, 32'h10, 2, 0, 32'h0, 1, 4'h0, 16'd4, 32'h0, 32'hDEADBEEF, 0);
    req(1, 32'h13, 0, 0, 32'h55555580, 1, 4'h8, 16'd4, 32'h80808080, 32'h0, 0);
    req(0, 32'h13, 0, 1, 32'h0, 1, 4'h0, 16'd4, 32'h0, 32'hFFFFFF80, 0);
    req(0, 32'h13, 0, 0, 32'h0, 1, 4'h0, 16'd4, 32'h0, 32'h00000080, 0);
    req(0, 32'h10, 0, 1, 32'h0, 1, 4'h0, 16'd4, 32'h0, 32'hFFFFFFEF, 0);
    req(0, 32'h10, 0, 0, 32'h0, 1, 4'h0, 16'd4, 32'h0, 32'h000000EF, 0);
    req(0, 32'h11, 0, 1, 32'h0, 1, 4'h0, 16'd4, 32'h0, 32'hFFFFFFBE, 0);
    req(0, 32'h10, 2, 1, 32'h0, 1, 4'h0, 16'd4, 32'h0, 32'h80ADBEEF, 0);
    req(1, 32'h22, 1, 0, 32'h12348001, 1, 4'hC, 16'd8, 32'h80018001, 32'h0, 0);
    req(0, 32'h22, 1, 1, 32'h0, 1, 4'h0, 16'd8, 32'h0, 32'hFFFF8001, 0);
    req(0, 32'h22, 1, 0, 32'h0, 1, 4'h0, 16'd8, 32'h0, 32'h00008001, 0);
    req(0, 32'h20, 1, 1, 32'h0, 1, 4'h0, 16'd8, 32'h0, 32'h00000000, 0);
    req(1, 32'h21, 1, 0, 32'hFFFFFFFF, 0, 4'h0, 16'd8, 32'h0, 32'h0, 1);
    req(1, 32'h22, 2, 0, 32'hFFFFFFFF, 0, 4'h0, 16'd8, 32'h0, 32'h0, 1);
    req(1, 32'h20, 3, 0, 32'hFFFFFFFF, 0, 4'h0, 16'd8, 32'h0, 32'h0, 1);
    req(0, 32'h21, 1, 1, 32'h0, 0, 4'h0, 16'd8, 32'h0, 32'h0, 1);
    req(0, 32'h20, 2, 0, 32'h0, 1, 4'h0, 16'd8, 32'h0, 32'h80010000, 0);
    req(1, (32'h1 << 18) + 32'h4, 2, 0, 32'h11223344, 1, 4'hF, 16'd1, 32'h11223344, 32'h0, 0);
    req(0, 32'h4, 2, 0, 32'h0, 1, 4'h0, 16'd1, 32'h0, 32'h11223344, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 32'h10;
    bus.req_size = 2'd2;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'h80ADBEEF);
      chk("bp_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", bus.rsp_valid, 0);
    chk("bp_release_ready", bus.req_ready, 1);
    req(0, 32'h13, 0, 0, 32'h0, 1, 4'h0, 16'd4, 32'h0, 32'h00000080, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 32'h10;
    bus.req_size = 2'd2;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_req_ready", bus.req_ready, 0);
    chk("mr_mem_ena", bus.mem_ena, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("mr_ready_after", bus.req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_no_stale", bus.rsp_valid, 0);
    end
    req(0, 32'h22, 1, 1, 32'h0, 1, 4'h0, 16'd8, 32'h0, 32'hFFFF8001, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_lsu_bridge.md
Name: sram_lsu_bridge

Overview:
Load/store front end for the word-organised, byte-writable synchronous SRAM. Sits directly upstream of the SRAM macro. Converts CPU byte-addressed load/store requests into:
- SRAM word address
- Byte write mask
- Lane-replicated write data
It also absorbs the SRAM's one-cycle read latency and returns aligned, sign/zero-extended load data over a valid/ready response channel.

Parameters:
ADDR_WIDTH, 16, SRAM word-address width; byte address bits [ADDR_WIDTH+1:2] select the word.

Ports:
clk  in  1  clock; also drives the SRAM clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  bridge can accept a request
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_signed  in  1  loads only: sign-extend when 1
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load data, extended; 0 for stores and errors
rsp_err  out  1  misaligned or illegal-size request
mem_ena  out  1  SRAM enable
mem_wea  out  4  SRAM byte write enables
mem_addra  out  ADDR_WIDTH  SRAM word address
mem_dina  out  32  SRAM write data
mem_douta  in  32  SRAM read data, valid the cycle after an enabled access

Behaviour:
- Reset (async, rst=1): state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; internal offset/size/signed registers cleared.
- SRAM outputs are combinational from the request:
  - mem_ena=0 and mem_wea=0 whenever no access is launched.
- FSM states: IDLE, RD_WAIT, RESP.
- req_ready=1 only in IDLE. Accept = req_valid & req_ready, in cycle T.
- Error check at accept:
  - err = (size==3) | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0).
  - On err: no SRAM access (mem_ena=0, mem_wea=0); go to RESP with rsp_err=1, rsp_rdata=0.
- Legal store at T:
  - mem_ena=1; mem_addra=addr[ADDR_WIDTH+1:2].
  - mem_wea: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
  - mem_dina: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - Next state RESP with rsp_err=0, rsp_rdata=0. rsp_valid first high in T+1.
- Legal load at T:
  - mem_ena=1, mem_wea=0.
  - Latch addr[1:0], size and signed.
  - Go to RD_WAIT.
- RD_WAIT (T+1):
  - mem_ena=0.
  - Extract lane from mem_douta: byte = douta[8*off+:8]; half = douta[16*off[1]+:16].
  - Extend by the signed flag; register into rsp_rdata; go to RESP.
  - rsp_valid first high in T+2.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_valid & rsp_ready. That edge → IDLE.
- Throughput:
  - Store or error: 1 request per 2 cycles with rsp_ready tied high.
  - Load: 1 request per 3 cycles.
- Address bits above ADDR_WIDTH+1 are ignored; the address wraps modulo SRAM size, no error.
- req_signed is ignored for stores and word loads.
- Inputs other than req_valid are don't-care when req_valid=0. Request fields are sampled only at accept.
- Reset asserted mid-operation:
  - Immediately IDLE, with the response dropped.
  - A store whose accept edge already occurred is committed in SRAM.
  - A pending load is discarded.
  - No SRAM access is launched while rst=1: req_ready=0 and mem_ena=0 during reset.

Test Plan:
- Word store/load: store 0xDEADBEEF @0x10 → mem_wea=1111, mem_addra=4, rsp_valid at T+1 with err=0. Load word @0x10 → rsp_rdata=0xDEADBEEF at T+2.
- Byte lanes: store byte 0x80 @0x13 → wea=1000, dina=0x80808080. Then:
  - Signed byte load @0x13 → 0xFFFFFF80.
  - Unsigned byte load @0x13 → 0x00000080.
  - Unsigned byte load @0x10 → 0xEF (other bytes unchanged).
- Halfword: store half 0x8001 @0x22 → wea=1100, dina=0x80018001. Then:
  - Signed half load @0x22 → 0xFFFF8001.
  - Unsigned half load @0x22 → 0x00008001.
- Errors: half @0x21, word @0x22, size=3 @0x20 → each gives mem_ena=0, rsp_err=1, rsp_rdata=0 at T+1; memory contents unchanged on readback.
- Backpressure: load with rsp_ready=0 for 5 cycles → rsp_valid stays 1 and rsp_rdata stays constant; req_ready=0 throughout. rsp_ready=1 → IDLE the next cycle and a new request is accepted.
- Reset mid-load: assert rst in RD_WAIT → rsp_valid=0 immediately; after release, req_ready=1 and no stale response appears. Wrap: store @(1<<(ADDR_WIDTH+2))+4 → mem_addra=1.
